mdu_seq: RTL and testbench
==========================

MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (legal: 8, 16, 32).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request; accepted only in IDLE.
REQ-005 SHALL have port op  input  1  0 = multiply (MPY), 1 = divide (DIV).
REQ-006 SHALL have port acc_in  input  WIDTH  multiplicand / dividend (accumulator value).
REQ-007 SHALL have port br_in  input  WIDTH  multiplier / divisor (buffer register value).
REQ-008 SHALL have port busy  output  1  high from the cycle after acceptance until done.
REQ-009 SHALL have port done  output  1  single-cycle completion pulse.
REQ-010 SHALL have port acc_out  output  WIDTH  product low half / quotient.
REQ-011 SHALL have port mr_out  output  WIDTH  product high half / remainder.
REQ-012 SHALL have port dbz  output  1  divide-by-zero flag for the last completed operation.
REQ-013 SHALL have port illegal_op  output  1  unsupported-op flag for the last completed operation.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> FINISH -> IDLE.
REQ-015 IDLE: start=1 SHALL latch op, acc_in and br_in, clear the iteration counter, and go to RUN; start=0 stays in IDLE.
REQ-016 RUN SHALL perform exactly WIDTH iterations, one per cycle, then go to FINISH.
REQ-017 MPY iteration: unsigned shift-add on a 2*WIDTH product register; the final product is exact.
REQ-018 DIV iteration: unsigned restoring division; quotient bit = 1 when the partial remainder >= divisor.
REQ-019 FINISH SHALL update acc_out/mr_out/dbz/illegal_op, pulse done for one cycle, and return to IDLE.
REQ-020 Latency: with start sampled at edge N, done SHALL be high in cycle N+WIDTH+2; busy SHALL be high in cycles N+1 through N+WIDTH+1.
REQ-021 DIV with br_in=0 SHALL skip RUN (IDLE -> FINISH) and give acc_out = all ones, mr_out = dividend, dbz = 1.
REQ-022 start while busy SHALL be ignored, with no queuing and no corruption of the operation in progress.
REQ-023 start in the done cycle SHALL be ignored; it is accepted from the next IDLE cycle.
REQ-024 Outputs SHALL hold their values from FINISH until the next FINISH.
REQ-025 Input changes after acceptance SHALL NOT affect the result.

Reset
REQ-026 rst=1 SHALL immediately force IDLE and busy = done = dbz = illegal_op = 0, acc_out = mr_out = 0, counter = 0.
REQ-027 rst asserted mid-RUN SHALL abort the operation with no done pulse; after release the block accepts a new start.

Configuration
REQ-028 Macro MDU_DIV_EN defined SHALL compile in the divide datapath and REQ-018/REQ-021.
REQ-029 Without MDU_DIV_EN, op=1 SHALL go IDLE -> FINISH and give acc_out = mr_out = 0, illegal_op = 1, dbz = 0; MPY is unchanged.

Structure
REQ-030 Package mdu_pkg SHALL hold the op encodings (OP_MPY, OP_DIV) and the state enum (ST_IDLE, ST_RUN, ST_FINISH).
REQ-031 Sub-module mdu_step (combinational, one MPY or DIV iteration) SHALL be instantiated once by mdu_seq.

Verification
REQ-032 WIDTH=16, MPY acc_in=0x1234, br_in=0x0010 -> done at start+18; acc_out=0x2340, mr_out=0x0001.
REQ-033 MPY 0xFFFF x 0xFFFF -> acc_out=0x0001, mr_out=0xFFFE, dbz=0.
REQ-034 DIV 100 / 7 (MDU_DIV_EN) -> acc_out=14, mr_out=2, done at start+18; DIV 0x0005 / 0 -> acc_out=0xFFFF, mr_out=0x0005, dbz=1, done at start+2.
REQ-035 start pulsed at cycles +3 and +17 during MPY -> single done at +18, result from the first operands only.
REQ-036 rst raised at RUN iteration 8 -> busy=0 and acc_out=0 at once, no done; a new MPY 3 x 4 then returns acc_out=12.
REQ-037 Build without MDU_DIV_EN, DIV 10 / 2 -> illegal_op=1, acc_out=mr_out=0, done at start+2.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the sequential multiply/divide unit.
package mdu_pkg;

   localparam logic OP_MPY = 1'b0;
   localparam logic OP_DIV = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration of the shift-add multiplier or restoring divider.
// p_in/p_out hold {high half, low half}: product high/low for MPY,
// partial remainder/quotient for DIV. The divide path exists only when
// MDU_DIV_EN is defined.
module mdu_step
   import mdu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               op,
   input  logic [2*WIDTH-1:0] p_in,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] p_out
);

   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     mpy_sum;
   logic [2*WIDTH-1:0] mpy_p;

   // Shift-add: add the multiplicand when the multiplier LSB is set, then shift right with carry.
   always_comb begin
      addend  = p_in[0] ? b : '0;
      mpy_sum = {1'b0, p_in[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      mpy_p   = {mpy_sum, p_in[WIDTH-1:1]};
   end

`ifdef MDU_DIV_EN
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH-1:0]   rem_sub;
   logic [2*WIDTH-1:0] div_p;

   // Restoring step: shift the next dividend bit in, subtract only when it fits.
   always_comb begin
      rem_sh  = p_in[2*WIDTH-1:WIDTH-1];
      rem_sub = rem_sh[WIDTH-1:0] - b;
      if (rem_sh >= {1'b0, b}) begin
         div_p = {rem_sub, p_in[WIDTH-2:0], 1'b1};
      end else begin
         div_p = {rem_sh[WIDTH-1:0], p_in[WIDTH-2:0], 1'b0};
      end
   end

   assign p_out = (op == OP_DIV) ? div_p : mpy_p;
`else
   // Without the divider an unsupported op simply holds the register.
   assign p_out = (op == OP_MPY) ? mpy_p : p_in;
`endif

endmodule

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit, WIDTH iterations per operation.
// Build option: define MDU_DIV_EN to include unsigned division; otherwise
// a divide request completes at once with illegal_op set.
//
// Handshake: start is sampled on a rising edge only while the FSM is IDLE and
// done is low; operands are captured at that edge. busy is high from the next
// cycle until the FINISH cycle ends; done pulses for exactly one cycle, in the
// same cycle the new acc_out/mr_out/dbz/illegal_op first appear. Starts seen
// while busy or during done are dropped, never queued.
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] acc_in,
   input  logic [WIDTH-1:0] br_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] acc_out,
   output logic [WIDTH-1:0] mr_out,
   output logic             dbz,
   output logic             illegal_op,
   output state_t           state_dbg
);

   localparam int CW = $clog2(WIDTH);

   state_t             state;
   logic [CW-1:0]      cnt;
   logic               op_r;
   logic [WIDTH-1:0]   b_r;
   logic [2*WIDTH-1:0] p_r;
   logic [2*WIDTH-1:0] p_next;

   assign state_dbg = state;

   mdu_step #(.WIDTH(WIDTH)) u_step (
      .op   (op_r),
      .p_in (p_r),
      .b    (b_r),
      .p_out(p_next)
   );

   // Control FSM, datapath registers and registered result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         op_r       <= OP_MPY;
         b_r        <= '0;
         p_r        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         acc_out    <= '0;
         mr_out     <= '0;
         dbz        <= 1'b0;
         illegal_op <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && !done) begin
                  op_r <= op;
                  cnt  <= '0;
                  busy <= 1'b1;
                  if (op == OP_DIV) begin
                     b_r <= br_in;
                     p_r <= {{WIDTH{1'b0}}, acc_in};
`ifdef MDU_DIV_EN
                     // A zero divisor has a fixed answer, so the iterations are skipped.
                     state <= (br_in == '0) ? ST_FINISH : ST_RUN;
`else
                     state <= ST_FINISH;
`endif
                  end else begin
                     b_r   <= acc_in;
                     p_r   <= {{WIDTH{1'b0}}, br_in};
                     state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               p_r <= p_next;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= ST_IDLE;
               if (op_r == OP_DIV) begin
`ifdef MDU_DIV_EN
                  if (b_r == '0) begin
                     acc_out    <= '1;
                     mr_out     <= p_r[WIDTH-1:0];
                     dbz        <= 1'b1;
                  end else begin
                     acc_out    <= p_r[WIDTH-1:0];
                     mr_out     <= p_r[2*WIDTH-1:WIDTH];
                     dbz        <= 1'b0;
                  end
                  illegal_op <= 1'b0;
`else
                  acc_out    <= '0;
                  mr_out     <= '0;
                  dbz        <= 1'b0;
                  illegal_op <= 1'b1;
`endif
               end else begin
                  acc_out    <= p_r[WIDTH-1:0];
                  mr_out     <= p_r[2*WIDTH-1:WIDTH];
                  dbz        <= 1'b0;
                  illegal_op <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq at WIDTH=16: directed corner cases plus random operations
// checked against an arithmetic reference model.
module tb_mdu_seq;
   import mdu_pkg::*;

   localparam int W  = 16;
   localparam int EW = 2*W + 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          op;
   logic [W-1:0]  acc_in;
   logic [W-1:0]  br_in;
   logic          busy;
   logic          done;
   logic [W-1:0]  acc_out;
   logic [W-1:0]  mr_out;
   logic          dbz;
   logic          illegal_op;
   state_t        state_dbg;

   int checks = 0;
   int errors = 0;
   logic [EW-1:0] exp_q[$];

   mdu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .acc_in    (acc_in),
      .br_in     (br_in),
      .busy      (busy),
      .done      (done),
      .acc_out   (acc_out),
      .mr_out    (mr_out),
      .dbz       (dbz),
      .illegal_op(illegal_op),
      .state_dbg (state_dbg)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
      end
   endtask

   // Reference: {acc_out, mr_out, dbz, illegal_op} from plain arithmetic.
   function automatic logic [EW-1:0] model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] prod;
      if (o == 1'b0) begin
         prod = (2*W)'(a) * (2*W)'(b);
         return {prod[W-1:0], prod[2*W-1:W], 1'b0, 1'b0};
      end
`ifdef MDU_DIV_EN
      if (b == 0) return {{W{1'b1}}, a, 1'b1, 1'b0};
      return {W'(a / b), W'(a % b), 1'b0, 1'b0};
`else
      return {{W{1'b0}}, {W{1'b0}}, 1'b0, 1'b1};
`endif
   endfunction

   function automatic int exp_latency(input logic o, input logic [W-1:0] b);
      if (o == 1'b0) return W + 2;
`ifdef MDU_DIV_EN
      return (b == 0) ? 2 : W + 2;
`else
      return 2;
`endif
   endfunction

   task automatic do_reset();
      rst    = 1'b1;
      start  = 1'b0;
      op     = 1'b0;
      acc_in = '0;
      br_in  = '0;
      #1;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset acc_out", acc_out, 0);
      check("reset mr_out", mr_out, 0);
      check("reset dbz", dbz, 0);
      check("reset illegal_op", illegal_op, 0);
      check("reset state", state_dbg, ST_IDLE);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Issue one operation, scramble inputs after acceptance, optionally poke
   // start while busy and in the done cycle, then score the result.
   task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit poke, input bit retrig, input string tag);
      int k;
      bit seen;
      bit busy_ok;
      logic [EW-1:0] e;
      int lat;
      exp_q.push_back(model(o, a, b));
      lat = exp_latency(o, b);
      @(negedge clk);
      start  = 1'b1;
      op     = o;
      acc_in = a;
      br_in  = b;
      @(posedge clk);
      #1;
      start  = 1'b0;
      op     = 1'($urandom);
      acc_in = W'($urandom);
      br_in  = W'($urandom);
      k = 1;
      seen = 0;
      busy_ok = 1;
      while (!seen && k <= 40) begin
         if (done === 1'b1) begin
            seen = 1;
         end else begin
            if (busy !== 1'b1) busy_ok = 0;
            if (poke && (k == 3 || k == 17)) begin
               start  = 1'b1;
               op     = 1'($urandom);
               acc_in = W'($urandom);
               br_in  = W'($urandom);
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            k++;
         end
      end
      e = exp_q.pop_front();
      check({tag, " latency"}, k, lat);
      check({tag, " busy during op"}, busy_ok, 1);
      check({tag, " busy at done"}, busy, 0);
      check({tag, " acc_out"}, acc_out, e[EW-1 -: W]);
      check({tag, " mr_out"}, mr_out, e[W+1 -: W]);
      check({tag, " dbz"}, dbz, e[1]);
      check({tag, " illegal_op"}, illegal_op, e[0]);
      if (retrig) begin
         start  = 1'b1;
         op     = 1'b0;
         acc_in = W'($urandom);
         br_in  = W'($urandom);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      check({tag, " done one cycle"}, done, 0);
      check({tag, " acc_out hold"}, acc_out, e[EW-1 -: W]);
      if (retrig) begin
         check({tag, " start in done ignored"}, busy, 0);
      end
   endtask

   initial begin
      int aborted_done;
      logic rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      do_reset();

      run_op(1'b0, 16'h1234, 16'h0010, 0, 0, "mpy 1234x0010");
      run_op(1'b0, 16'hFFFF, 16'hFFFF, 0, 0, "mpy ffffxffff");
      run_op(1'b0, 16'h0000, 16'hBEEF, 0, 0, "mpy zero");
      run_op(1'b0, 16'h00AB, 16'h0123, 1, 0, "mpy poked");
      run_op(1'b0, 16'h7001, 16'h0003, 0, 1, "mpy retrig");
`ifdef MDU_DIV_EN
      run_op(1'b1, 16'd100, 16'd7, 0, 0, "div 100/7");
      run_op(1'b1, 16'h0005, 16'h0000, 0, 0, "div by zero");
      run_op(1'b1, 16'hFFFF, 16'h0001, 0, 0, "div ffff/1");
      run_op(1'b1, 16'h0003, 16'hFFFF, 1, 0, "div small/large");
`else
      run_op(1'b1, 16'd10, 16'd2, 0, 0, "div disabled");
      run_op(1'b1, 16'h0005, 16'h0000, 0, 0, "div0 disabled");
`endif
      run_op(1'b0, 16'h0102, 16'h0304, 0, 0, "mpy before abort");

      // Abort mid-RUN after eight iterations.
      @(negedge clk);
      start  = 1'b1;
      op     = 1'b0;
      acc_in = 16'h00AB;
      br_in  = 16'h00CD;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort busy", busy, 0);
      check("abort acc_out", acc_out, 0);
      check("abort done", done, 0);
      check("abort state", state_dbg, ST_IDLE);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      aborted_done = 0;
      for (int i = 0; i < W + 6; i++) begin
         @(negedge clk);
         if (done !== 1'b0) aborted_done++;
      end
      check("abort no done", aborted_done, 0);
      run_op(1'b0, 16'd3, 16'd4, 0, 0, "mpy 3x4 after abort");

      // Random operations, occasionally with a zero second operand.
      for (int n = 0; n < 24; n++) begin
         rop = 1'($urandom_range(0, 1));
         ra  = W'($urandom);
         rb  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
         run_op(rop, ra, rb, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
